// File: rtl/pha_pkg.sv
// Shared types and widths for the pulse height analyzer and related spectroscopy blocks.
package pha_pkg;

    localparam int unsigned CNT_W   = 32;
    localparam int unsigned WIDTH_W = 14;
    localparam int unsigned SHIFT_W = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRACK   = 2'd1,
        REJECT  = 2'd2,
        HOLDOFF = 2'd3
    } pha_state_e;

endpackage

// File: rtl/pha_saturate.sv
// Arithmetic right shift of a signed 2W value, clamped into the unsigned W-bit range.
module pha_saturate
    import pha_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic signed [2*W-1:0]     value_i,
    input  logic        [SHIFT_W-1:0] shift_i,
    output logic        [W-1:0]       height_c
);

    logic signed [2*W-1:0] shifted;

    assign shifted = value_i >>> shift_i;

    // Negative clamps to zero; any set bit above the W-bit field clamps to full scale.
    always_comb begin
        height_c = shifted[W-1:0];
        if (shifted[2*W-1]) begin
            height_c = '0;
        end else if (|shifted[2*W-2:W]) begin
            height_c = '1;
        end
    end

endmodule

// File: rtl/pulse_height_analyzer.sv
// Thresholds the trapezoidal filter stream, tracks each pulse peak, rejects pile-up
// and emits one saturated height per event on an AXI-Stream master.
module pulse_height_analyzer
    import pha_pkg::*;
#(
    parameter int unsigned AXIS_TDATA_WIDTH = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic signed [2*AXIS_TDATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                                  s_axis_tvalid,
    output logic        [AXIS_TDATA_WIDTH-1:0]    m_axis_tdata,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    input  logic signed [2*AXIS_TDATA_WIDTH-1:0]  threshold,
    input  logic        [WIDTH_W-1:0]             holdoff,
    input  logic        [WIDTH_W-1:0]             max_width,
    input  logic        [SHIFT_W-1:0]             shift,
    output logic        [CNT_W-1:0]               event_count,
    output logic        [CNT_W-1:0]               drop_count,
    output logic        [CNT_W-1:0]               pileup_count
);

    localparam int unsigned W  = AXIS_TDATA_WIDTH;
    localparam int unsigned DW = 2 * AXIS_TDATA_WIDTH;

    pha_state_e               state_q;
    logic signed [DW-1:0]     peak_q;
    logic        [WIDTH_W-1:0] width_q;
    logic        [WIDTH_W-1:0] hold_q;
    logic        [W-1:0]      tdata_q;
    logic                     tvalid_q;
    logic        [CNT_W-1:0]  event_q;
    logic        [CNT_W-1:0]  drop_q;
    logic        [CNT_W-1:0]  pileup_q;

    logic                     above_c;
    logic                     emit_c;
    logic                     out_free_c;
    logic signed [DW-1:0]     peak_max_c;
    logic        [WIDTH_W-1:0] width_inc_c;
    logic        [W-1:0]      height_c;

    assign above_c     = s_axis_tdata > threshold;
    assign emit_c      = s_axis_tvalid && (state_q == TRACK) && !above_c;
    assign out_free_c  = !tvalid_q || m_axis_tready;
    assign peak_max_c  = (s_axis_tdata > peak_q) ? s_axis_tdata : peak_q;
    assign width_inc_c = (&width_q) ? width_q : WIDTH_W'(width_q + WIDTH_W'(1));

    pha_saturate #(
        .W        (W)
    ) u_saturate (
        .value_i  (peak_q),
        .shift_i  (shift),
        .height_c (height_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            peak_q   <= '0;
            width_q  <= '0;
            hold_q   <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            event_q  <= '0;
            drop_q   <= '0;
            pileup_q <= '0;
        end else begin
            // Output register: a handshake in the same cycle frees the slot for a new height.
            if (emit_c && out_free_c) begin
                tdata_q  <= height_c;
                tvalid_q <= 1'b1;
                event_q  <= CNT_W'(event_q + CNT_W'(1));
            end else begin
                if (emit_c) begin
                    drop_q <= CNT_W'(drop_q + CNT_W'(1));
                end
                if (tvalid_q && m_axis_tready) begin
                    tvalid_q <= 1'b0;
                end
            end

            if (s_axis_tvalid) begin
                case (state_q)
                    IDLE: begin
                        if (above_c) begin
                            peak_q  <= s_axis_tdata;
                            width_q <= WIDTH_W'(1);
                            // A limit of one sample already counts as reached on the trigger sample.
                            if (max_width == WIDTH_W'(1)) begin
                                pileup_q <= CNT_W'(pileup_q + CNT_W'(1));
                                state_q  <= REJECT;
                            end else begin
                                state_q  <= TRACK;
                            end
                        end
                    end
                    TRACK: begin
                        if (above_c) begin
                            peak_q  <= peak_max_c;
                            width_q <= width_inc_c;
                            if ((max_width != '0) && (width_inc_c >= max_width)) begin
                                pileup_q <= CNT_W'(pileup_q + CNT_W'(1));
                                state_q  <= REJECT;
                            end
                        end else begin
                            hold_q  <= holdoff;
                            state_q <= (holdoff == '0) ? IDLE : HOLDOFF;
                        end
                    end
                    REJECT: begin
                        if (!above_c) begin
                            hold_q  <= holdoff;
                            state_q <= (holdoff == '0) ? IDLE : HOLDOFF;
                        end
                    end
                    HOLDOFF: begin
                        if (hold_q <= WIDTH_W'(1)) begin
                            state_q <= IDLE;
                        end else begin
                            hold_q <= WIDTH_W'(hold_q - WIDTH_W'(1));
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign event_count   = event_q;
    assign drop_count    = drop_q;
    assign pileup_count  = pileup_q;

endmodule
